// File: rtl/logip_pkg.sv
// rtl/logip_pkg.sv - shared readout FSM state type and default memory depth
package logip_pkg;

  localparam int DEPTH_LOG2_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    HOLD
  } readout_state_t;

endpackage

// File: rtl/sample_readout.sv
// rtl/sample_readout.sv - walks sample memory backwards from the newest address and
// streams one 32-bit word per transfer into the UART transmitter strobe/ready port
module sample_readout
  import logip_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DEPTH_LOG2-1:0] last_addr_i,
  input  logic [CNT_W-1:0]      read_cnt_i,
  output logic                  mem_rd_o,
  output logic [DEPTH_LOG2-1:0] mem_addr_o,
  input  logic [31:0]           mem_data_i,
  output logic                  tx_stb_o,
  output logic [31:0]           tx_data_o,
  input  logic                  tx_rdy_i,
  output logic                  busy_o,
  output logic                  done_o
);

  readout_state_t        state, state_next;
  logic [DEPTH_LOG2-1:0] addr, addr_next;
  logic [CNT_W-1:0]      remaining, remaining_next;
  logic [31:0]           data_next;
  logic                  stb_next, done_next, mem_rd_next, busy_next;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      tx_data_o <= '0;
      tx_stb_o  <= 1'b0;
      done_o    <= 1'b0;
      mem_rd_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      tx_data_o <= data_next;
      tx_stb_o  <= stb_next;
      done_o    <= done_next;
      mem_rd_o  <= mem_rd_next;
      busy_o    <= busy_next;
    end
  end

  always_comb begin
    state_next     = state;
    addr_next      = addr;
    remaining_next = remaining;
    data_next      = tx_data_o;
    stb_next       = 1'b0;
    done_next      = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          addr_next      = last_addr_i;
          remaining_next = read_cnt_i;
          state_next     = FETCH;
        end
      end
      FETCH: state_next = LATCH;
      LATCH: begin
        data_next  = mem_data_i;
        state_next = SEND;
      end
      SEND: begin
        // Strobe and done are registered, so both land in the HOLD cycle.
        if (tx_rdy_i) begin
          stb_next   = 1'b1;
          done_next  = (remaining == '0);
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (remaining == '0) begin
          state_next = IDLE;
        end else begin
          remaining_next = remaining - 1'b1;
          addr_next      = addr - 1'b1;
          state_next     = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort discards everything this cycle would have latched or launched.
    if (abort_i) begin
      state_next     = IDLE;
      addr_next      = addr;
      remaining_next = remaining;
      data_next      = tx_data_o;
      stb_next       = 1'b0;
      done_next      = 1'b0;
    end

    mem_rd_next = (state_next == FETCH);
    busy_next   = (state_next != IDLE);
  end

  assign mem_addr_o = addr;

endmodule

// File: tb/tb_sample_readout.sv
// tb/tb_sample_readout.sv - directed bench for sample_readout with a registered memory model
module tb_sample_readout;

  localparam int DL2 = 4;
  localparam int CW  = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [DL2-1:0] last_addr;
  logic [CW-1:0]  read_cnt;
  logic           mem_rd;
  logic [DL2-1:0] mem_addr;
  logic [31:0]    mem_data;
  logic           tx_stb;
  logic [31:0]    tx_data;
  logic           tx_rdy;
  logic           busy;
  logic           done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]    stb_q[$];
  logic [DL2-1:0] addr_q[$];
  int             n_done = 0;
  int             n_b2b = 0;
  logic           stb_prev = 1'b0;

  sample_readout #(.DEPTH_LOG2(DL2), .CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_in     (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .last_addr_i(last_addr),
    .read_cnt_i (read_cnt),
    .mem_rd_o   (mem_rd),
    .mem_addr_o (mem_addr),
    .mem_data_i (mem_data),
    .tx_stb_o   (tx_stb),
    .tx_data_o  (tx_data),
    .tx_rdy_i   (tx_rdy),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory holds address x 0x01010101, data valid one cycle after the read.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= 32'(mem_addr) * 32'h01010101;
  end

  always @(negedge clk) begin
    if (tx_stb) stb_q.push_back(tx_data);
    if (done) n_done++;
    if (mem_rd) addr_q.push_back(mem_addr);
    if (tx_stb && stb_prev) n_b2b++;
    stb_prev = tx_stb;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    stb_q.delete();
    addr_q.delete();
    n_done = 0;
  endtask

  task automatic kick(input logic [DL2-1:0] la, input logic [CW-1:0] rc);
    last_addr = la;
    read_cnt  = rc;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int unstable;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_rdy = 1'b0;
    last_addr = '0; read_cnt = '0; mem_data = '0;
    #12;
    check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_tx_stb", 32'(tx_stb), 32'd0);
    check_eq("rst_tx_data", tx_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic count with ready tied high
    tx_rdy = 1'b1;
    clear_log();
    kick(4'd5, 16'd2);
    check_eq("lat_busy", 32'(busy), 32'd1);
    check_eq("lat_mem_rd", 32'(mem_rd), 32'd1);
    check_eq("lat_addr", 32'(mem_addr), 32'd5);
    tick();
    check_eq("lat_latch_rd", 32'(mem_rd), 32'd0);
    wait_idle(100);
    check_eq("basic_n", stb_q.size(), 32'd3);
    if (stb_q.size() == 3) begin
      check_eq("basic_w0", stb_q[0], 32'h05050505);
      check_eq("basic_w1", stb_q[1], 32'h04040404);
      check_eq("basic_w2", stb_q[2], 32'h03030303);
    end
    check_eq("basic_done", n_done, 32'd1);

    // Address wrap at depth 16
    clear_log();
    kick(4'd1, 16'd3);
    wait_idle(100);
    check_eq("wrap_n", addr_q.size(), 32'd4);
    if (addr_q.size() == 4) begin
      check_eq("wrap_a0", 32'(addr_q[0]), 32'd1);
      check_eq("wrap_a1", 32'(addr_q[1]), 32'd0);
      check_eq("wrap_a2", 32'(addr_q[2]), 32'd15);
      check_eq("wrap_a3", 32'(addr_q[3]), 32'd14);
    end
    if (stb_q.size() == 4) check_eq("wrap_w2", stb_q[2], 32'h0F0F0F0F);
    check_eq("wrap_done", n_done, 32'd1);

    // Backpressure: 50 cycles of no ready while in SEND
    tx_rdy = 1'b0;
    clear_log();
    kick(4'd7, 16'd0);
    tick();
    tick();
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_stb !== 1'b0 || tx_data !== 32'h07070707) unstable++;
      tick();
    end
    check_eq("bp_unstable", unstable, 32'd0);
    check_eq("bp_busy", 32'(busy), 32'd1);
    tx_rdy = 1'b1;
    check_eq("bp_stb_pre", 32'(tx_stb), 32'd0);
    tick();
    check_eq("bp_stb_post", 32'(tx_stb), 32'd1);
    check_eq("bp_done", 32'(done), 32'd1);
    wait_idle(20);
    check_eq("bp_n", stb_q.size(), 32'd1);

    // Abort during word 2 of 4
    clear_log();
    kick(4'd9, 16'd3);
    n = 0;
    while (!tx_stb && n < 20) begin
      tick();
      n++;
    end
    check_eq("ab_first_stb", 32'(tx_stb), 32'd1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_busy", 32'(busy), 32'd0);
    check_eq("ab_mem_rd", 32'(mem_rd), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check_eq("ab_n", stb_q.size(), 32'd1);
    if (stb_q.size() >= 1) check_eq("ab_w0", stb_q[0], 32'h09090909);
    check_eq("ab_done", n_done, 32'd0);
    start = 1'b1; abort = 1'b1; last_addr = 4'd2; read_cnt = 16'd0;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("ab_start_coinc", 32'(busy), 32'd0);
    clear_log();
    kick(4'd3, 16'd0);
    wait_idle(50);
    check_eq("ab_re_n", stb_q.size(), 32'd1);
    if (stb_q.size() == 1) check_eq("ab_re_w0", stb_q[0], 32'h03030303);
    check_eq("ab_re_done", n_done, 32'd1);

    // Asynchronous reset mid-SEND
    tx_rdy = 1'b0;
    kick(4'd4, 16'd1);
    tick();
    tick();
    check_eq("rs_pre_data", tx_data, 32'h04040404);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rs_busy", 32'(busy), 32'd0);
    check_eq("rs_tx_data", tx_data, 32'd0);
    check_eq("rs_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rs_stb_rd_done", {29'd0, tx_stb, mem_rd, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Start while busy is ignored
    tx_rdy = 1'b1;
    clear_log();
    kick(4'd6, 16'd2);
    tick();
    tick();
    kick(4'd12, 16'd0);
    wait_idle(100);
    check_eq("bs_n", stb_q.size(), 32'd3);
    if (stb_q.size() == 3) begin
      check_eq("bs_w0", stb_q[0], 32'h06060606);
      check_eq("bs_w2", stb_q[2], 32'h04040404);
    end
    check_eq("bs_done", n_done, 32'd1);
    check_eq("b2b_strobes", n_b2b, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
